bist_march_ctrl: RTL and testbench
==================================

# bist_march_ctrl

Built-in self-test sequencer for the single-port `memory` block. On `start` it runs a March C- algorithm over every address of the array, drives the memory's address, read, write and data-in pins, and checks every read against the expected pattern. It reports `done` and a sticky `fail` flag with the first failing address and march element. It sits between the top-level test controller and the memory, in front of the functional-path mux.

## Interface

Parameters:
- `width`, 2, memory word width.
- `a_width`, 4, memory address width; depth N = 2**a_width.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  one-cycle pulse; begins a test when idle.
- `mem_address`  out  a_width  address to memory.
- `mem_write`  out  1  memory write strobe.
- `mem_read`  out  1  memory read strobe.
- `mem_data_in`  out  width  write data to memory.
- `mem_data_out`  in  width  read data from memory; valid the cycle after `mem_read`.
- `busy`  out  1  test in progress.
- `done`  out  1  high from test end until next accepted `start`.
- `fail`  out  1  sticky mismatch flag.
- `fail_address`  out  a_width  address of the first mismatch.
- `fail_element`  out  3  march element (0–5) of the first mismatch.

## Operation

- Background pattern D0 = all zeros. D1 = all ones (`{width{1'b1}}`).
- March elements, in order:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- ⇑ runs addresses 0..N-1. ⇓ runs N-1..0.
- FSM states: IDLE, RD, CMP, WR, DONE.
  - IDLE: `start`=1 clears `done`/`fail`/`fail_*` and goes to WR (M0, address 0).
  - RD: `mem_read`=1 and `mem_address` = current address.
  - CMP: no strobes. Compares `mem_data_out` with the expected value. Then goes to WR, or for M5 advances to the next address.
  - WR: `mem_write`=1, `mem_data_in` = element's write value. Then advances to the next address.
  - Address advance: after the last address of an element, move to the next element's first address and first op, with no extra cycle. After the last M5 CMP, go to DONE.
  - DONE: `done`=1, `busy`=0. Returns to IDLE in the same cycle. `done` holds until the next `start`.
- First mismatch: sets `fail`=1 and latches `fail_address`/`fail_element`. Later mismatches do not update them.
- `start` while `busy` is ignored.
- Address counter is exactly a_width bits. Direction is chosen per element, so there is no wrap-around.

## Timing

- Reset values: `busy`=0, `done`=0, `fail`=0, `fail_address`=0, `fail_element`=0, `mem_address`=0, `mem_read`=0, `mem_write`=0, `mem_data_in`=0.
- All outputs are registered. Memory strobes are never both high in the same cycle.
- `start` is sampled at cycle 0. `busy` goes high in cycle 1, when the first WR is presented.
- Cycle counts per address: M0 takes 1 cycle, M1–M4 take 3, M5 takes 2. Total T = 15·N cycles (240 for N=16).
- `done` rises and `busy` falls T cycles after `busy` rose.
- Reset mid-test aborts immediately. All outputs return to reset values and no memory strobe is issued after reset asserts.
- `start` coincident with DONE→IDLE is accepted on the following cycle only.

## Configuration

- `BIST_STOP_ON_FAIL_EN` defined:
  - The first mismatch ends the test. The FSM goes to DONE the cycle after that CMP.
  - `done`=1 and `fail`=1, with `fail_*` latched.
- Undefined:
  - The test always runs the full T cycles.
  - `fail` is sticky and `fail_*` hold the first mismatch.

## Test plan

- Fault-free 16×2 memory, pulse `start` → 240 busy cycles, then `done`=1 and `fail`=0. Address trace: 0..15 for M0–M2 and M5, 15..0 for M3–M4.
- Stuck-at-1 on bit 0 of address 5 → `fail`=1, `fail_address`=5, `fail_element`=1 (first r0 reads 01).
- Stuck-at-0 on bit 1 of address 12, macro undefined → `fail_address`=12, `fail_element`=2, and `done` still arrives at cycle 240. Macro defined → `done` right after the M2 address-12 CMP.
- Reset (`rst`=0) asserted mid-M3 → all outputs 0 in the same cycle. After release, a new `start` runs a clean 240-cycle pass.
- `start` pulsed at cycle 50 of a run → ignored, and total duration stays 240 cycles.
- Second `start` after `done` with the fault removed → `fail` cleared at start and 0 at the end.

Source files
------------

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl
// March C- built-in self-test sequencer for a single-port synchronous memory.
// A start pulse runs six march elements over every address:
//   M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0)
// Each read is checked against the expected background. The first mismatch
// raises a sticky fail flag and latches its address and element number.
//
// Parameters:
//   width    memory word width
//   a_width  memory address width (depth = 2**a_width)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   start         one-cycle pulse, starts a test when idle
//   mem_address   address to memory
//   mem_write     memory write strobe
//   mem_read      memory read strobe
//   mem_data_in   write data to memory
//   mem_data_out  read data from memory, valid the cycle after mem_read
//   busy          test in progress
//   done          test finished, held until the next accepted start
//   fail          sticky mismatch flag
//   fail_address  address of the first mismatch
//   fail_element  march element (0..5) of the first mismatch
//
// Optional build macro:
//   BIST_STOP_ON_FAIL_EN  when defined, the first mismatch ends the test
//                         immediately; otherwise the full march always runs.

module bist_march_ctrl #(
  parameter int width   = 2,
  parameter int a_width = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [a_width-1:0] mem_address,
  output logic               mem_write,
  output logic               mem_read,
  output logic [width-1:0]   mem_data_in,
  input  logic [width-1:0]   mem_data_out,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [a_width-1:0] fail_address,
  output logic [2:0]         fail_element
);

`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit stop_on_fail = 1'b1;
`else
  localparam bit stop_on_fail = 1'b0;
`endif

  localparam logic [a_width-1:0] addr_max = '1;
  localparam logic [2:0]         last_elem = 3'd5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CMP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [2:0]         elem_reg, elem_next;
  logic [a_width-1:0] addr_reg, addr_next;

  logic               mem_read_reg, mem_write_reg;
  logic [width-1:0]   mem_data_in_reg;
  logic               busy_reg, done_reg, fail_reg;
  logic [a_width-1:0] fail_address_reg;
  logic [2:0]         fail_element_reg;

  logic               elem_down;
  logic               next_elem_down;
  logic               last_addr;
  logic [a_width-1:0] step_addr;
  logic [width-1:0]   expect_val;
  logic               mismatch;
  logic               start_accept;

  // M3 and M4 walk the array downwards; all other elements walk upwards.
  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Write value of each element: M1 and M3 write ones, M0/M2/M4 write zeros.
  function automatic logic [width-1:0] write_val(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {width{1'b1}} : {width{1'b0}};
  endfunction

  assign elem_down      = is_down(elem_reg);
  assign next_elem_down = is_down(elem_reg + 3'd1);
  assign last_addr      = elem_down ? (addr_reg == '0) : (addr_reg == addr_max);
  assign step_addr      = elem_down ? (addr_reg - 1'b1) : (addr_reg + 1'b1);
  // M2 and M4 read back ones; M1, M3 and M5 read back zeros.
  assign expect_val     = ((elem_reg == 3'd2) || (elem_reg == 3'd4)) ?
                          {width{1'b1}} : {width{1'b0}};
  assign mismatch       = (state_reg == CMP) && (mem_data_out != expect_val);
  // A start arriving in DONE is dropped; only IDLE accepts it.
  assign start_accept   = (state_reg == IDLE) && start;

  always_comb begin
    state_next = state_reg;
    elem_next  = elem_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WR;
          elem_next  = 3'd0;
          addr_next  = '0;
        end
      end
      RD: begin
        state_next = CMP;
      end
      CMP: begin
        if (stop_on_fail && mismatch) begin
          state_next = DONE;
        end else if (elem_reg != last_elem) begin
          state_next = WR;
        end else if (last_addr) begin
          state_next = DONE;
        end else begin
          addr_next  = step_addr;
          state_next = RD;
        end
      end
      WR: begin
        if (!last_addr) begin
          addr_next  = step_addr;
          state_next = (elem_reg == 3'd0) ? WR : RD;
        end else begin
          // Every element after M0 starts with a read, so the element
          // boundary never costs an extra cycle.
          elem_next  = elem_reg + 3'd1;
          addr_next  = next_elem_down ? addr_max : '0;
          state_next = RD;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      elem_reg  <= 3'd0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      elem_reg  <= elem_next;
      addr_reg  <= addr_next;
    end
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // lines up with the state it belongs to and never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_data_in_reg <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      mem_read_reg    <= (state_next == RD);
      mem_write_reg   <= (state_next == WR);
      mem_data_in_reg <= (state_next == WR) ? write_val(elem_next) : '0;
      busy_reg        <= (state_next == RD) || (state_next == CMP) ||
                         (state_next == WR);
      if (start_accept) begin
        done_reg <= 1'b0;
      end else if (state_next == DONE) begin
        done_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_reg         <= 1'b0;
      fail_address_reg <= '0;
      fail_element_reg <= 3'd0;
    end else if (start_accept) begin
      fail_reg         <= 1'b0;
      fail_address_reg <= '0;
      fail_element_reg <= 3'd0;
    end else if (mismatch && !fail_reg) begin
      fail_reg         <= 1'b1;
      fail_address_reg <= addr_reg;
      fail_element_reg <= elem_reg;
    end
  end

  assign mem_address  = addr_reg;
  assign mem_read     = mem_read_reg;
  assign mem_write    = mem_write_reg;
  assign mem_data_in  = mem_data_in_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign fail         = fail_reg;
  assign fail_address = fail_address_reg;
  assign fail_element = fail_element_reg;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb_bist_march_ctrl
// Self-checking bench for bist_march_ctrl (16 x 2 memory). A behavioural
// memory with an injectable stuck-at fault sits on the memory pins. Each run
// pushes the expected March C- access trace into a queue; every busy cycle
// pops one entry and compares the strobes, address and write data.
// Run records (fault, expected busy length, expected fail report) come from
// a table; reset-at-mid-M3 is a hand-written sequence.

module tb_bist_march_ctrl;

  localparam int W  = 2;
  localparam int AW = 4;
  localparam int N  = 16;

`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic          mem_read;
  logic [W-1:0]  mem_data_in;
  logic [W-1:0]  mem_data_out;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_address;
  logic [2:0]    fail_element;

  always #5 clk = ~clk;

  bist_march_ctrl #(.width(W), .a_width(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_address  (mem_address),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_address (fail_address),
    .fail_element (fail_element)
  );

  // ---------------- behavioural memory with stuck-at fault ----------------
  logic [W-1:0]  mem [N];
  logic [AW-1:0] fault_addr = '0;
  logic [W-1:0]  sa1_mask = '0;
  logic [W-1:0]  sa0_mask = '0;

  initial mem_data_out = '0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
    if (mem_read) begin
      if (mem_address == fault_addr)
        mem_data_out <= (mem[mem_address] | sa1_mask) & ~sa0_mask;
      else
        mem_data_out <= mem[mem_address];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } acc_t;

  acc_t sb_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected access trace of a full march, one entry per busy cycle.
  task automatic build_trace();
    acc_t e;
    sb_q.delete();
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < N; i++) begin
        logic [AW-1:0] a;
        a = (el == 3 || el == 4) ? AW'(N - 1 - i) : AW'(i);
        if (el == 0) begin
          e = '{rd: 1'b0, wr: 1'b1, addr: a, data: '0};
          sb_q.push_back(e);
        end else begin
          e = '{rd: 1'b1, wr: 1'b0, addr: a, data: '0};
          sb_q.push_back(e);
          e = '{rd: 1'b0, wr: 1'b0, addr: a, data: '0};
          sb_q.push_back(e);
          if (el < 5) begin
            e = '{rd: 1'b0, wr: 1'b1, addr: a,
                  data: (el % 2 == 1) ? {W{1'b1}} : {W{1'b0}}};
            sb_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic pop_compare();
    acc_t e;
    acc_t act;
    if (sb_q.size() == 0) begin
      chk("trace_overrun", 32'(sb_q.size()), 32'd1);
    end else begin
      e   = sb_q.pop_front();
      act = '{rd: mem_read, wr: mem_write,
              addr: (mem_read | mem_write) ? mem_address : '0,
              data: mem_write ? mem_data_in : '0};
      if (!(e.rd | e.wr)) e.addr = '0;
      chk("trace", 32'(act), 32'(e));
    end
  endtask

  // ---------------- run table ----------------
  typedef struct {
    logic [AW-1:0] faddr;
    logic [W-1:0]  sa1;
    logic [W-1:0]  sa0;
    bit            restart;
    int            exp_busy;
    bit            exp_fail;
    logic [AW-1:0] exp_fa;
    logic [2:0]    exp_fe;
  } rec_t;

  rec_t recs[5];

  task automatic do_run(input int id);
    rec_t r;
    int   cyc;
    int   guard;
    r = recs[id];
    fault_addr = r.faddr;
    sa1_mask   = r.sa1;
    sa0_mask   = r.sa0;
    build_trace();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    guard = 0;
    while (!done && guard < 1000) begin
      if (busy) begin
        cyc++;
        if (cyc == 1)
          chk("cleared_at_start", {28'd0, fail, done, fail_address[0], fail_element[0]}, 32'd0);
        pop_compare();
      end
      start = r.restart && (cyc == 50);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk("done_timeout", 32'(guard < 1000), 32'd1);
    chk("busy_cycles", 32'(cyc), 32'(r.exp_busy));
    chk("fail_flag", 32'(fail), 32'(r.exp_fail));
    chk("fail_address", 32'(fail_address), 32'(r.exp_fa));
    chk("fail_element", 32'(fail_element), 32'(r.exp_fe));
    chk("busy_at_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_held", {30'd0, done, busy}, 32'd2);
    $display("run %0d: busy=%0d fail=%0d fa=%0d fe=%0d", id, cyc, fail, fail_address, fail_element);
    sb_q.delete();
  endtask

  initial begin
    recs[0] = '{faddr: 4'd0,  sa1: 2'b00, sa0: 2'b00, restart: 1'b0,
                exp_busy: 240, exp_fail: 1'b0, exp_fa: 4'd0,  exp_fe: 3'd0};
    recs[1] = '{faddr: 4'd5,  sa1: 2'b01, sa0: 2'b00, restart: 1'b0,
                exp_busy: STOP ? 33 : 240, exp_fail: 1'b1, exp_fa: 4'd5,  exp_fe: 3'd1};
    recs[2] = '{faddr: 4'd12, sa1: 2'b00, sa0: 2'b10, restart: 1'b0,
                exp_busy: STOP ? 102 : 240, exp_fail: 1'b1, exp_fa: 4'd12, exp_fe: 3'd2};
    recs[3] = '{faddr: 4'd0,  sa1: 2'b00, sa0: 2'b00, restart: 1'b0,
                exp_busy: 240, exp_fail: 1'b0, exp_fa: 4'd0,  exp_fe: 3'd0};
    recs[4] = '{faddr: 4'd0,  sa1: 2'b00, sa0: 2'b00, restart: 1'b1,
                exp_busy: 240, exp_fail: 1'b0, exp_fa: 4'd0,  exp_fe: 3'd0};

    // Reset values while rst is held low.
    #3;
    chk("reset_values",
        32'({busy, done, fail, fail_address, fail_element, mem_address,
             mem_read, mem_write, mem_data_in}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {29'd0, busy, done, fail}, 32'd0);

    for (int i = 0; i < 5; i++) do_run(i);

    // Reset asserted in the middle of M3 (busy cycles 113..160).
    fault_addr = '0; sa1_mask = '0; sa0_mask = '0;
    build_trace();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (busy) pop_compare();
      else chk("busy_before_reset", 32'(busy), 32'd1);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("reset_mid_m3",
        32'({busy, done, fail, fail_address, fail_element, mem_address,
             mem_read, mem_write, mem_data_in}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_strobe_in_reset", {29'd0, mem_read, mem_write, busy}, 32'd0);
    end
    rst = 1'b1;
    sb_q.delete();
    $display("run reset_mid_m3: aborted");
    do_run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
